// File: rtl/div_sequencer_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | div_sequencer_pkg : shared types and constants for the divide sequencer |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
package div_sequencer_pkg;

   localparam int DIV_ITERS = 32;

   typedef struct packed {
      logic signed_;
      logic rem;
   } divop_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } divstate_t;

endpackage
`default_nettype wire

// File: rtl/div_sequencer_if.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | div_sequencer_if : execute-stage <-> divider request/result bundle      |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
interface div_sequencer_if #(
   parameter int XLEN = 32
);
   logic            div_req;
   logic            div_signed;
   logic            div_rem;
   logic [XLEN-1:0] div_a;
   logic [XLEN-1:0] div_b;
   logic            div_kill;
   logic            div_busy;
   logic            div_done;
   logic [XLEN-1:0] div_result;

   modport master (
      output div_req, div_signed, div_rem, div_a, div_b, div_kill,
      input  div_busy, div_done, div_result
   );

   modport slave (
      input  div_req, div_signed, div_rem, div_a, div_b, div_kill,
      output div_busy, div_done, div_result
   );
endinterface
`default_nettype wire

// File: rtl/div_sequencer_step.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | div_step : one combinational radix-2 restoring divide iteration         |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module div_step #(
   parameter int XLEN = 32
) (
   input  wire logic [XLEN-1:0] rem,
   input  wire logic [XLEN-1:0] quo,
   input  wire logic [XLEN-1:0] divisor,
   output logic      [XLEN-1:0] rem_nxt,
   output logic      [XLEN-1:0] quo_nxt
);
   logic [XLEN:0] w_shift;
   logic [XLEN:0] w_trial;

   // rem < divisor holds between steps, so the shifted value fits XLEN+1 bits
   assign w_shift = {rem, quo[XLEN-1]};
   assign w_trial = w_shift - {1'b0, divisor};

   assign rem_nxt = w_trial[XLEN] ? w_shift[XLEN-1:0] : w_trial[XLEN-1:0];
   assign quo_nxt = {quo[XLEN-2:0], ~w_trial[XLEN]};
endmodule
`default_nettype wire

// File: rtl/div_sequencer.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | div_sequencer : iterative DIV/DIVU/REM/REMU controller (XLEN steps)     |
// | Optional: DIV_EARLY_OUT_EN skips iteration when |a| < |b|               |
// | Revision 1.0                                                            |
// +-------------------------------------------------------------------------+
module div_sequencer
   import div_sequencer_pkg::*;
#(
   parameter int XLEN = DIV_ITERS
) (
   input  wire logic        clk_core,
   input  wire logic        reset,
   div_sequencer_if.slave   bus
);
   localparam int CW = $clog2(XLEN);

   divstate_t       r_state;
   divop_t          r_op;
   logic            r_neg;
   logic [CW-1:0]   r_count;
   logic [XLEN-1:0] r_rem;
   logic [XLEN-1:0] r_quo;
   logic [XLEN-1:0] r_divisor;
   logic [XLEN-1:0] r_result;

   logic            w_accept;
   logic            w_a_neg;
   logic            w_b_neg;
   logic [XLEN-1:0] w_abs_a;
   logic [XLEN-1:0] w_abs_b;
   logic            w_div_zero;
   logic            w_ovf;
   logic            w_early;
   logic [XLEN-1:0] w_rem_nxt;
   logic [XLEN-1:0] w_quo_nxt;
   logic [XLEN-1:0] w_sel;
   logic [XLEN-1:0] w_final;

   assign w_accept   = (r_state == IDLE) & bus.div_req & ~bus.div_kill & ~reset;
   assign w_a_neg    = bus.div_signed & bus.div_a[XLEN-1];
   assign w_b_neg    = bus.div_signed & bus.div_b[XLEN-1];
   assign w_abs_a    = w_a_neg ? (~bus.div_a + 1'b1) : bus.div_a;
   assign w_abs_b    = w_b_neg ? (~bus.div_b + 1'b1) : bus.div_b;
   assign w_div_zero = (bus.div_b == '0);
   assign w_ovf      = bus.div_signed & (bus.div_a == {1'b1, {(XLEN-1){1'b0}}})
                       & (bus.div_b == '1);

`ifdef DIV_EARLY_OUT_EN
   assign w_early = (w_abs_a < w_abs_b);
`else
   assign w_early = 1'b0;
`endif

   div_step #(.XLEN(XLEN)) u_step (
      .rem     (r_rem),
      .quo     (r_quo),
      .divisor (r_divisor),
      .rem_nxt (w_rem_nxt),
      .quo_nxt (w_quo_nxt)
   );

   assign w_sel   = r_op.rem ? w_rem_nxt : w_quo_nxt;
   assign w_final = (r_op.signed_ & r_neg) ? (~w_sel + 1'b1) : w_sel;

   always_ff @(posedge clk_core) begin
      if (reset) begin
         r_state   <= IDLE;
         r_op      <= '0;
         r_neg     <= 1'b0;
         r_count   <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_divisor <= '0;
         r_result  <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               r_result <= '0;
               if (w_accept) begin
                  r_op.signed_ <= bus.div_signed;
                  r_op.rem     <= bus.div_rem;
                  // raw sign; only applied when the op is signed
                  r_neg        <= bus.div_rem ? bus.div_a[XLEN-1]
                                              : (bus.div_a[XLEN-1] ^ bus.div_b[XLEN-1]);
                  if (w_div_zero) begin
                     r_result <= bus.div_rem ? bus.div_a : '1;
                     r_state  <= DONE;
                  end else if (w_ovf) begin
                     r_result <= bus.div_rem ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                     r_state  <= DONE;
                  end else if (w_early) begin
                     r_result <= bus.div_rem ? bus.div_a : '0;
                     r_state  <= DONE;
                  end else begin
                     r_rem     <= '0;
                     r_quo     <= w_abs_a;
                     r_divisor <= w_abs_b;
                     r_count   <= '0;
                     r_state   <= ITER;
                  end
               end
            end
            ITER: begin
               if (bus.div_kill) begin
                  r_count <= '0;
                  r_state <= IDLE;
               end else begin
                  r_rem   <= w_rem_nxt;
                  r_quo   <= w_quo_nxt;
                  r_count <= r_count + 1'b1;
                  if (r_count == CW'(XLEN-1)) begin
                     r_result <= w_final;
                     r_state  <= DONE;
                  end
               end
            end
            DONE: begin
               r_result <= '0;
               r_state  <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.div_busy   = (r_state != IDLE) | w_accept;
   assign bus.div_done   = (r_state == DONE) & ~bus.div_kill & ~reset;
   assign bus.div_result = r_result;
endmodule
`default_nettype wire
